pipe_scheduler: RTL and testbench

//  Owns the pipe-slot resource consumed by the frame renderer. It spawns, scrolls and retires
//  NUM_PIPES obstacle slots on each game tick, and randomises gap heights with an LFSR.
//  It also counts pipes cleared by the bird. It sits between the game tick source and the

---
 rtl/flappy_pkg.sv | 30 +++
 rtl/pipe_scheduler_if.sv | 30 +++
 rtl/pipe_scheduler_lfsr8.sv | 25 ++
 rtl/pipe_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_pipe_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game datapath: pipe slot record,
// scheduler state encoding and the LFSR feedback function.
package flappy_pkg;

    localparam int COORD_W   = 10;
    localparam int PIPE_BITS = 2 * COORD_W;

    localparam int MAX_X  = 320;
    localparam int MAX_Y  = 240;
    localparam int PIPE_W = 30;
    localparam int GAP_H  = 70;
    localparam int BIRD_X = 30;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] gap_top;
    } pipe_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } sched_state_e;

    // Fibonacci form of x^8+x^6+x^5+x^4+1; the all-zero state is unreachable from a non-zero seed.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Control strobes in, packed slot array and status out, between the tick source,
// the pipe scheduler and the renderer/collision logic.
interface pipe_scheduler_if
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = 3
);

    logic                           tick;
    logic                           start;
    logic                           pause;
    logic                           clear;
    logic [NUM_PIPES*PIPE_BITS-1:0] pipes;
    logic [NUM_PIPES-1:0]           pipe_valid;
    logic [7:0]                     score;
    logic                           score_pulse;
    logic                           spawn_drop;
    logic                           running;

    modport master (
        output tick, start, pause, clear,
        input  pipes, pipe_valid, score, score_pulse, spawn_drop, running
    );

    modport slave (
        input  tick, start, pause, clear,
        output pipes, pipe_valid, score, score_pulse, spawn_drop, running
    );

endinterface

// File: rtl/pipe_scheduler_lfsr8.sv
// 8-bit maximal-length LFSR with a loadable reset seed; advances only when stepped.
module lfsr8
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= seed;
        end else if (step) begin
            r_q <= lfsr8_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Spawns, scrolls and retires obstacle slots on each game tick in RUN, randomises
// gap heights and counts pipes cleared by the bird.
module pipe_scheduler #(
    parameter int         NUM_PIPES      = 3,
    parameter int         MAX_X          = flappy_pkg::MAX_X,
    parameter int         PIPE_W         = flappy_pkg::PIPE_W,
    parameter int         GAP_MIN        = 20,
    parameter int         SPAWN_INTERVAL = 110,
    parameter int         SPEED          = 1,
    parameter int         BIRD_X         = flappy_pkg::BIRD_X,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input logic             clk,
    input logic             rst_n,
    pipe_scheduler_if.slave bus
);

    import flappy_pkg::pipe_t;
    import flappy_pkg::sched_state_e;
    import flappy_pkg::ST_IDLE;
    import flappy_pkg::ST_RUN;
    import flappy_pkg::ST_PAUSED;

    localparam int                CNT_W     = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int                SUM_W     = $clog2(NUM_PIPES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [9:0]        X_PARK    = 10'(MAX_X);
    localparam logic [9:0]        X_STEP    = 10'(SPEED);
    localparam logic [9:0]        GAP_BASE  = 10'(GAP_MIN);
    localparam logic [10:0]       EDGE_W    = 11'(PIPE_W);
    localparam logic [10:0]       EDGE_BIRD = 11'(BIRD_X);

    sched_state_e           r_state;
    sched_state_e           w_state_next;

    pipe_t [NUM_PIPES-1:0]  w_pipes;
    logic  [NUM_PIPES-1:0]  w_valid;
    logic  [NUM_PIPES-1:0]  w_alive;
    logic  [NUM_PIPES-1:0]  w_scored;
    logic  [NUM_PIPES-1:0]  w_first_free;
    logic  [NUM_PIPES-1:0]  w_spawn_sel;

    logic [7:0]             r_score;
    logic                   r_score_pulse;
    logic                   r_spawn_drop;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_run_tick;
    logic                   w_spawn_due;
    logic                   w_free_found;
    logic                   w_spawn;
    logic                   w_drop;
    logic [SUM_W-1:0]       w_score_cnt;
    logic [8:0]             w_score_sum;
    logic [7:0]             w_lfsr;
    logic                   w_lfsr_msb_unused;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_next = r_state;
        if (bus.clear) begin
            w_state_next = ST_IDLE;
        end else if (bus.pause) begin
            if (r_state == ST_RUN) begin
                w_state_next = ST_PAUSED;
            end else if (r_state == ST_PAUSED) begin
                w_state_next = ST_RUN;
            end
        end else if (bus.start && (r_state == ST_IDLE)) begin
            w_state_next = ST_RUN;
        end
    end

    // A tick that coincides with clear is swallowed; clear wins over everything.
    assign w_run_tick  = (r_state == ST_RUN) && bus.tick && !bus.clear;
    assign w_spawn_due = (r_cnt == CNT_LAST);

    // ---------------------------------------------------------------- slots
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_slot
        pipe_t       r_slot;
        logic        r_live;
        logic [9:0]  w_moved_x;
        logic [10:0] w_old_edge;
        logic [10:0] w_new_edge;

        assign w_alive[g]  = r_live && (r_slot.x >= X_STEP);
        assign w_moved_x   = w_alive[g] ? (r_slot.x - X_STEP) : 10'd0;
        assign w_old_edge  = {1'b0, r_slot.x} + EDGE_W;
        assign w_new_edge  = {1'b0, w_moved_x} + EDGE_W;
        assign w_scored[g] = w_run_tick && r_live &&
                             (w_old_edge > EDGE_BIRD) && (w_new_edge <= EDGE_BIRD);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot.x       <= X_PARK;
                r_slot.gap_top <= '0;
                r_live         <= 1'b0;
            end else if (bus.clear) begin
                r_slot.x       <= X_PARK;
                r_slot.gap_top <= '0;
                r_live         <= 1'b0;
            end else if (w_run_tick) begin
                if (w_spawn_sel[g]) begin
                    r_slot.x       <= X_PARK;
                    r_slot.gap_top <= GAP_BASE + {3'b000, w_lfsr[6:0]};
                    r_live         <= 1'b1;
                end else if (w_alive[g]) begin
                    r_slot.x <= w_moved_x;
                end else begin
                    r_slot.x <= X_PARK;
                    r_live   <= 1'b0;
                end
            end
        end

        assign w_pipes[g] = r_slot;
        assign w_valid[g] = r_live;
    end

    // Lowest-index slot still free after this tick's retirements.
    always_comb begin
        w_first_free = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!w_alive[i] && (w_first_free == '0)) begin
                w_first_free[i] = 1'b1;
            end
        end
    end

    assign w_free_found = |w_first_free;
    assign w_spawn      = w_run_tick && w_spawn_due && w_free_found;
    assign w_drop       = w_run_tick && w_spawn_due && !w_free_found;
    assign w_spawn_sel  = w_spawn ? w_first_free : '0;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (w_run_tick && w_spawn_due),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    assign w_lfsr_msb_unused = w_lfsr[7];

    // ---------------------------------------------------------------- score / counter
    always_comb begin
        w_score_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_score_cnt = w_score_cnt + SUM_W'(w_scored[i]);
        end
    end

    assign w_score_sum = {1'b0, r_score} + 9'(w_score_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score       <= '0;
            r_score_pulse <= 1'b0;
            r_spawn_drop  <= 1'b0;
            r_cnt         <= CNT_LAST;
        end else if (bus.clear) begin
            r_score       <= '0;
            r_score_pulse <= 1'b0;
            r_spawn_drop  <= 1'b0;
            r_cnt         <= CNT_LAST;
        end else begin
            r_score_pulse <= |w_scored;
            r_spawn_drop  <= w_drop;
            if (w_run_tick) begin
                r_score <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
                r_cnt   <= w_spawn_due ? '0 : (r_cnt + CNT_W'(1));
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.pipes       = w_pipes;
    assign bus.pipe_valid  = w_valid;
    assign bus.score       = r_score;
    assign bus.score_pulse = r_score_pulse;
    assign bus.spawn_drop  = r_spawn_drop;
    assign bus.running     = (r_state == ST_RUN);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Drives two schedulers (default spawn interval and a fast interval of 2) with directed
// and random stimulus, comparing every cycle against a behavioural model of the game rules.
module tb_pipe_scheduler;

    localparam int NP      = 3;
    localparam int X_PARK  = 320;
    localparam int PIPE_W  = 30;
    localparam int BIRD_X  = 30;
    localparam int GAP_MIN = 20;
    localparam int SPEED   = 1;
    localparam int SEED    = 'hA5;

    logic clk = 1'b0;
    logic rst_n;
    logic tick, start, pause, clear;

    always #5 clk = ~clk;

    pipe_scheduler_if #(.NUM_PIPES(NP)) bus_a ();
    pipe_scheduler_if #(.NUM_PIPES(NP)) bus_b ();

    assign bus_a.tick  = tick;
    assign bus_a.start = start;
    assign bus_a.pause = pause;
    assign bus_a.clear = clear;
    assign bus_b.tick  = tick;
    assign bus_b.start = start;
    assign bus_b.pause = pause;
    assign bus_b.clear = clear;

    pipe_scheduler dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pipe_scheduler #(.SPAWN_INTERVAL(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic [NP*20-1:0] obs_pipes [2];
    logic [NP-1:0]    obs_valid [2];
    logic [7:0]       obs_score [2];
    logic [2:0]       obs_flags [2];

    assign obs_pipes[0] = bus_a.pipes;
    assign obs_valid[0] = bus_a.pipe_valid;
    assign obs_score[0] = bus_a.score;
    assign obs_flags[0] = {bus_a.score_pulse, bus_a.spawn_drop, bus_a.running};
    assign obs_pipes[1] = bus_b.pipes;
    assign obs_valid[1] = bus_b.pipe_valid;
    assign obs_score[1] = bus_b.score;
    assign obs_flags[1] = {bus_b.score_pulse, bus_b.spawn_drop, bus_b.running};

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: 0 = idle, 1 = run, 2 = paused.
    int m_state [2];
    int m_x     [2][NP];
    int m_gap   [2][NP];
    bit m_valid [2][NP];
    int m_score [2];
    int m_lfsr  [2];
    int m_cnt   [2];
    bit m_pulse [2];
    bit m_drop  [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int interval_of(input int id);
        return (id == 0) ? 110 : 2;
    endfunction

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 'hFF;
    endfunction

    task automatic model_reset(input int id, input bit keep_lfsr);
        for (int i = 0; i < NP; i++) begin
            m_x[id][i]     = X_PARK;
            m_gap[id][i]   = 0;
            m_valid[id][i] = 1'b0;
        end
        m_score[id] = 0;
        m_pulse[id] = 1'b0;
        m_drop[id]  = 1'b0;
        m_cnt[id]   = interval_of(id) - 1;
        m_state[id] = 0;
        if (!keep_lfsr) m_lfsr[id] = SEED;
    endtask

    task automatic model_step(input int id, input bit tk, input bit st, input bit ps, input bit cl);
        int  scored;
        int  free_slot;
        int  nx;
        bit  due;
        m_pulse[id] = 1'b0;
        m_drop[id]  = 1'b0;
        if (cl) begin
            model_reset(id, 1'b1);
            return;
        end
        if (m_state[id] == 1 && tk) begin
            scored = 0;
            for (int i = 0; i < NP; i++) begin
                if (m_valid[id][i]) begin
                    nx = m_x[id][i] - SPEED;
                    if (m_x[id][i] + PIPE_W > BIRD_X && ((nx < 0) ? 0 : nx) + PIPE_W <= BIRD_X)
                        scored++;
                    if (nx < 0) begin
                        m_valid[id][i] = 1'b0;
                        m_x[id][i]     = X_PARK;
                    end else begin
                        m_x[id][i] = nx;
                    end
                end
            end
            due = (m_cnt[id] == interval_of(id) - 1);
            m_cnt[id] = due ? 0 : m_cnt[id] + 1;
            if (due) begin
                free_slot = -1;
                for (int i = 0; i < NP; i++)
                    if (!m_valid[id][i] && free_slot < 0) free_slot = i;
                if (free_slot >= 0) begin
                    m_valid[id][free_slot] = 1'b1;
                    m_x[id][free_slot]     = X_PARK;
                    m_gap[id][free_slot]   = GAP_MIN + (m_lfsr[id] % 128);
                end else begin
                    m_drop[id] = 1'b1;
                end
                m_lfsr[id] = lfsr_next(m_lfsr[id]);
            end
            m_score[id] = (m_score[id] + scored > 255) ? 255 : m_score[id] + scored;
            m_pulse[id] = (scored > 0);
        end
        if (ps) begin
            if (m_state[id] == 1)      m_state[id] = 2;
            else if (m_state[id] == 2) m_state[id] = 1;
        end else if (st && m_state[id] == 0) begin
            m_state[id] = 1;
        end
    endtask

    function automatic logic [NP*20-1:0] model_pipes(input int id);
        logic [NP*20-1:0] p;
        p = '0;
        for (int i = 0; i < NP; i++) p[20*i +: 20] = {10'(m_x[id][i]), 10'(m_gap[id][i])};
        return p;
    endfunction

    function automatic logic [NP-1:0] model_valid(input int id);
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = m_valid[id][i];
        return v;
    endfunction

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check((d == 0) ? "a pipes" : "b pipes", 64'(obs_pipes[d]), 64'(model_pipes(d)));
            check((d == 0) ? "a valid" : "b valid", 64'(obs_valid[d]), 64'(model_valid(d)));
            check((d == 0) ? "a score" : "b score", 64'(obs_score[d]), 64'(m_score[d]));
            check((d == 0) ? "a flags" : "b flags", 64'(obs_flags[d]),
                  64'({m_pulse[d], m_drop[d], m_state[d] == 1}));
        end
    endtask

    // Called at a falling edge: drive, predict, advance one clock, compare.
    task automatic cycle(input bit tk, input bit st, input bit ps, input bit cl);
        tick  = tk;
        start = st;
        pause = ps;
        clear = cl;
        for (int d = 0; d < 2; d++) model_step(d, tk, st, ps, cl);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [9:0] obs_x(input int d, input int i);
        return obs_pipes[d][20*i+10 +: 10];
    endfunction

    function automatic logic [9:0] obs_gap(input int d, input int i);
        return obs_pipes[d][20*i +: 10];
    endfunction

    initial begin
        logic [NP*20-1:0] parked;
        logic [NP*20-1:0] snap_pipes;
        int               snap_score;
        int               guard;
        int               pulses_obs;
        int               pulses_exp;

        for (int i = 0; i < NP; i++) parked[20*i +: 20] = {10'(X_PARK), 10'd0};

        rst_n = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        model_reset(0, 1'b0);
        model_reset(1, 1'b0);
        @(negedge clk);
        compare_all();
        check("reset pipes", 64'(bus_a.pipes), 64'(parked));
        check("reset valid", 64'(bus_a.pipe_valid), 64'd0);
        check("reset score", 64'(bus_a.score), 64'd0);
        check("reset running", 64'(bus_a.running), 64'd0);
        rst_n = 1'b1;

        // First tick after start spawns slot 0 with the seed-derived gap.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("start running", 64'(bus_a.running), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("spawn0 valid", 64'(bus_a.pipe_valid), 64'b001);
        check("spawn0 x", 64'(obs_x(0, 0)), 64'd320);
        check("spawn0 gap", 64'(obs_gap(0, 0)), 64'd57);
        check("spawn0 slot1 x", 64'(obs_x(0, 1)), 64'd320);

        // 110 more ticks: second spawn; the fast instance fills up and drops.
        for (int t = 2; t <= 111; t++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (t == 6) check("b full", 64'(bus_b.pipe_valid), 64'b111);
            if (t == 7) begin
                check("b drop pulse", 64'(bus_b.spawn_drop), 64'd1);
                check("b drop valid", 64'(bus_b.pipe_valid), 64'b111);
            end
        end
        check("t111 slot0 x", 64'(obs_x(0, 0)), 64'd210);
        check("t111 slot1 valid", 64'(bus_a.pipe_valid[1]), 64'd1);
        check("t111 slot1 x", 64'(obs_x(0, 1)), 64'd320);
        check("t111 score", 64'(bus_a.score), 64'd0);

        guard = 0;
        while (m_x[0][0] != 1 && guard < 400) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("reach x1 in budget", 64'(guard < 400), 64'd1);
        check("slot0 at x1", 64'(obs_x(0, 0)), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("score at x0", 64'(bus_a.score), 64'd1);
        check("pulse at x0", 64'(bus_a.score_pulse), 64'd1);
        check("slot0 x0", 64'(obs_x(0, 0)), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("slot0 retired", 64'(bus_a.pipe_valid[0]), 64'd0);
        check("slot0 parked", 64'(obs_x(0, 0)), 64'd320);

        // Pause freezes everything, resume continues, clear+tick returns to idle.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        snap_pipes = model_pipes(0);
        snap_score = m_score[0];
        for (int t = 0; t < 20; t++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause pipes", 64'(bus_a.pipes), 64'(snap_pipes));
        check("pause score", 64'(bus_a.score), 64'(snap_score));
        check("pause running", 64'(bus_a.running), 64'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume running", 64'(bus_a.running), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("clear valid", 64'(bus_a.pipe_valid), 64'd0);
        check("clear score", 64'(bus_a.score), 64'd0);
        check("clear running", 64'(bus_a.running), 64'd0);

        // Random control traffic.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 3000; t++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 199) == 0, $urandom_range(0, 999) == 0);
            for (int i = 0; i < NP; i++)
                if (bus_a.pipe_valid[i])
                    check("gap bottom", 64'(int'(obs_gap(0, i)) + flappy_pkg::GAP_H < flappy_pkg::MAX_Y), 64'd1);
        end

        // Asynchronous reset between clock edges mid-run.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 50; t++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async pipes", 64'(bus_a.pipes), 64'(parked));
        check("async valid", 64'(bus_a.pipe_valid), 64'd0);
        check("async score", 64'(bus_a.score), 64'd0);
        check("async running", 64'(bus_a.running), 64'd0);
        check("async b valid", 64'(bus_b.pipe_valid), 64'd0);
        model_reset(0, 1'b0);
        model_reset(1, 1'b0);
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Long run to saturate both scores, then keep scoring.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while ((m_score[0] < 255 || m_score[1] < 255) && guard < 40000) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("saturate in budget", 64'(guard < 40000), 64'd1);
        pulses_obs = 0;
        pulses_exp = 0;
        for (int t = 0; t < 400; t++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            pulses_obs += int'(bus_a.score_pulse);
            pulses_exp += int'(m_pulse[0]);
        end
        check("sat score a", 64'(bus_a.score), 64'd255);
        check("sat score b", 64'(bus_b.score), 64'd255);
        check("sat pulses", 64'(pulses_obs), 64'(pulses_exp));

        tick = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
